// File: rtl/mem_responder_if.sv
// proc2mem / mem2proc block interface between the memory controller and a memory responder.
interface mem_responder_if #(
  parameter int unsigned TAG_W = 4
);
  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic             stall;
  logic [TAG_W-1:0] mem2proc_transaction_tag;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, stall,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, stall,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts LOAD/STORE, issues tags, keeps a local block store and
// returns tagged load data a fixed number of cycles after acceptance.
module mem_responder #(
  parameter int unsigned DEPTH_BLOCKS    = 1024,
  parameter int unsigned LATENCY         = 12,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int unsigned IDX_W  = 29;
  localparam int unsigned MEM_AW = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0]       CMD_LOAD  = 2'd1;
  localparam logic [1:0]       CMD_STORE = 2'd2;
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_LAST  = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } resp_t;

  logic [63:0]       mem [DEPTH_BLOCKS];
  resp_t             pipe [LATENCY];
  logic [TAG_W-1:0]  next_tag;
  logic [CNT_W-1:0]  outstanding;
  logic [TAG_W-1:0]  data_tag_q;
  logic [63:0]       data_q;

  logic [IDX_W-1:0]  blk_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              is_load;
  logic              is_store;
  logic              accept;
  logic              load_acc;
  logic              store_acc;
  logic              retire;
  logic [63:0]       rd_data;

  // Request decode and accept decision; the full check sees only the registered count.
  always_comb begin
    blk_idx   = bus.proc2mem_addr[31:3];
    mem_idx   = blk_idx[MEM_AW-1:0];
    in_range  = (blk_idx < IDX_W'(DEPTH_BLOCKS));
    is_load   = (bus.proc2mem_command == CMD_LOAD);
    is_store  = (bus.proc2mem_command == CMD_STORE);
    accept    = !bus.stall &&
                (is_store || (is_load && (outstanding < CNT_W'(MAX_OUTSTANDING))));
    load_acc  = accept && is_load;
    store_acc = accept && is_store;
    retire    = pipe[LATENCY-1].valid;
    rd_data   = in_range ? mem[mem_idx] : 64'd0;
  end

  assign bus.mem2proc_transaction_tag = accept ? next_tag : '0;
  assign bus.mem2proc_data_tag        = data_tag_q;
  assign bus.mem2proc_data            = data_q;

  // Backing store is deliberately left out of reset; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (store_acc && in_range) begin
      mem[mem_idx] <= bus.proc2mem_data;
    end
  end

  // Load data is snapshotted at acceptance, then shifted toward the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
      data_tag_q <= '0;
      data_q     <= '0;
    end else begin
      pipe[0] <= load_acc ? resp_t'{valid: 1'b1, tag: next_tag, data: rd_data} : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      data_tag_q <= pipe[LATENCY-1].tag;
      data_q     <= pipe[LATENCY-1].data;
    end
  end

  // Tags run 1..max and wrap back to 1 so that 0 keeps meaning "refused".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_tag <= TAG_FIRST;
    end else if (accept) begin
      next_tag <= (next_tag == TAG_LAST) ? TAG_FIRST : next_tag + TAG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({load_acc, retire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic scored
// against a transaction-level model (block map + queue of due responses).
module tb_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 12;
  localparam int unsigned MAX_OUT = 8;
  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_LOAD  = 2'd1;
  localparam logic [1:0]  C_STORE = 2'd2;
  localparam logic [1:0]  C_RSVD  = 2'd3;

  typedef struct {
    int unsigned due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  mem_responder_if #(.TAG_W(4)) bus ();

  mem_responder #(
    .DEPTH_BLOCKS   (DEPTH),
    .LATENCY        (LATENCY),
    .MAX_OUTSTANDING(MAX_OUT),
    .TAG_W          (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned cyc      = 0;
  logic [3:0]  ntag     = 4'd1;
  exp_t        q[$];
  logic [63:0] model_mem [int unsigned];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: present a request, score outputs against the model, advance the model.
  task automatic step(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic stl, output logic [3:0] got);
    logic        acc;
    logic [63:0] exp_d;
    logic [3:0]  exp_tg;
    int unsigned blk;
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = addr;
    bus.proc2mem_data    = wdata;
    bus.stall            = stl;
    #1;
    exp_d  = '0;
    exp_tg = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_d  = q[0].data;
      exp_tg = q[0].tag;
      void'(q.pop_front());
    end
    chk("rsp_tag", 64'(bus.mem2proc_data_tag), 64'(exp_tg));
    chk("rsp_data", bus.mem2proc_data, exp_d);
    acc = (cmd == C_LOAD || cmd == C_STORE) && !stl &&
          (cmd == C_STORE || q.size() < MAX_OUT);
    got = bus.mem2proc_transaction_tag;
    chk("txn_tag", 64'(got), acc ? 64'(ntag) : 64'd0);
    blk = 32'(addr[31:3]);
    if (acc) begin
      if (cmd == C_STORE && blk < DEPTH) model_mem[blk] = wdata;
      if (cmd == C_LOAD)
        q.push_back('{cyc + 1 + LATENCY, ntag,
                      (blk < DEPTH && model_mem.exists(blk)) ? model_mem[blk] : 64'd0});
      ntag = (ntag == 4'd15) ? 4'd1 : ntag + 4'd1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    logic [3:0] t;
    for (int unsigned i = 0; i < n; i++) step(C_NONE, 32'd0, 64'd0, 1'b0, t);
  endtask

  // Asserts reset immediately (outputs must clear asynchronously), releases on a falling edge.
  task automatic apply_reset();
    bus.proc2mem_command = C_NONE;
    bus.stall            = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rsp_tag", 64'(bus.mem2proc_data_tag), 64'd0);
    chk("rst_rsp_data", bus.mem2proc_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    q.delete();
    ntag  = 4'd1;
    cyc   = 0;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  t;
    int          acc_cyc;
    int unsigned n_acc;
    int unsigned blk;
    logic [1:0]  cmd;

    reset                = 1'b0;
    bus.proc2mem_command = C_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.stall            = 1'b0;
    @(negedge clk);
    apply_reset();

    // Store then load of the same block.
    step(C_STORE, 32'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, t);
    chk("sl_store_tag", 64'(t), 64'd1);
    step(C_LOAD, 32'h40, 64'd0, 1'b0, t);
    chk("sl_load_tag", 64'(t), 64'd2);
    idle(LATENCY + 2);

    // Nine back-to-back loads; the ninth waits for the first response to retire.
    apply_reset();
    step(C_STORE, 32'h48, 64'h0123_4567_89AB_CDEF, 1'b0, t);
    apply_reset();
    n_acc   = 0;
    acc_cyc = -1;
    for (int i = 0; i < 40 && n_acc < 9; i++) begin
      step(C_LOAD, 32'h48, 64'd0, 1'b0, t);
      if (i == 8) chk("b2b_9th_refused", 64'(t), 64'd0);
      if (t != 4'd0) begin
        n_acc++;
        if (n_acc <= 8) chk("b2b_tag", 64'(t), 64'(n_acc));
        if (n_acc == 9) acc_cyc = i;
      end
    end
    chk("b2b_9th_accept_cycle", 64'(acc_cyc), 64'(LATENCY + 1));
    idle(LATENCY + 2);

    // Tag wrap over sixteen stores.
    apply_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      step(C_STORE, 32'(i * 8), {$urandom, $urandom}, 1'b0, t);
      chk("wrap_tag", 64'(t), (i < 15) ? 64'(i + 1) : 64'd1);
    end
    for (int unsigned i = 16; i < 64; i++) step(C_STORE, 32'(i * 8), {$urandom, $urandom}, 1'b0, t);

    // Snapshot ordering: store after an in-flight load does not affect it.
    step(C_STORE, 32'h80, 64'h11, 1'b0, t);
    step(C_LOAD, 32'h80, 64'd0, 1'b0, t);
    step(C_STORE, 32'h80, 64'h22, 1'b0, t);
    idle(LATENCY + 1);
    step(C_LOAD, 32'h80, 64'd0, 1'b0, t);
    idle(LATENCY + 1);

    // Stall, reserved command, out-of-range load and store.
    step(C_LOAD, 32'h40, 64'd0, 1'b1, t);
    chk("stall_tag", 64'(t), 64'd0);
    step(C_RSVD, 32'h40, 64'd5, 1'b0, t);
    chk("rsvd_tag", 64'(t), 64'd0);
    step(C_LOAD, 32'h0000_2000, 64'd0, 1'b0, t);
    step(C_STORE, 32'h0000_2000, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, t);
    step(C_LOAD, 32'h0, 64'd0, 1'b0, t);
    idle(LATENCY + 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      blk = ($urandom_range(0, 15) == 0) ? 1024 + $urandom_range(0, 4095) : $urandom_range(0, 63);
      cmd = 2'($urandom_range(0, 3));
      step(cmd, {blk[28:0], 3'($urandom_range(0, 7))}, {$urandom, $urandom},
           ($urandom_range(0, 7) == 0), t);
    end
    idle(LATENCY + 1);

    // Reset while loads are in flight and a response is on the bus.
    for (int unsigned i = 1; i <= 3; i++) step(C_LOAD, 32'(i * 8), 64'd0, 1'b0, t);
    for (int i = 0; i < 40 && !(q.size() > 0 && q[0].due == cyc); i++) idle(1);
    #1;
    chk("pre_rst_rsp_visible", 64'(bus.mem2proc_data_tag != 4'd0), 64'd1);
    apply_reset();
    idle(LATENCY + 4);
    step(C_LOAD, 32'h8, 64'd0, 1'b0, t);
    chk("post_rst_first_tag", 64'(t), 64'd1);
    idle(LATENCY + 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the proc2mem/mem2proc block interface that the memory controller drives.
- Accepts LOAD and STORE commands, issues transaction tags, holds a local block store, and returns load data tagged after a fixed latency.
- Replaces the behavioural memory model in unit and system benches, and acts as an on-chip backing store for the bitNN top.

Parameters:
- DEPTH_BLOCKS, 1024, number of 64-bit blocks in the backing store.
- LATENCY, 12, cycles from load acceptance to data return (must be at least 1).
- MAX_OUTSTANDING, 8, maximum in-flight loads (must be at most 15).
- TAG_W, 4, tag width; tag 0 means "none".

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2  command: 0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
- proc2mem_addr  in  32  byte address; bits [2:0] ignored, block index = addr[31:3].
- proc2mem_data  in  64  store data.
- stall  in  1  forces refusal of all requests this cycle (bench backpressure injection).
- mem2proc_transaction_tag  out  TAG_W  combinational; nonzero = request accepted this cycle with this tag, 0 = refused.
- mem2proc_data  out  64  registered load data.
- mem2proc_data_tag  out  TAG_W  registered; nonzero marks a valid response for that tag.

Behaviour:
- Reset (reset=0, async):
  - data_tag=0, data=0.
  - next_tag=1, outstanding=0, response pipeline cleared.
  - Backing store contents are not reset.
- Accept condition: cmd is LOAD or STORE, stall=0, and (cmd==STORE or outstanding<MAX_OUTSTANDING).
  - Full check ignores any same-cycle retire.
- Tag issue:
  - transaction_tag = next_tag when accepted, else 0.
  - next_tag advances on every accept, counting 1..15 then wrapping to 1; 0 is never issued.
  - Refused requests do not advance next_tag; the initiator re-presents them.
- STORE:
  - Block is written at the accepting edge.
  - No data response is returned and no outstanding slot is consumed.
- LOAD:
  - Block is read at the accepting edge (snapshot), so a later store to the same block does not alter an in-flight load.
  - Store and load to the same block in the same cycle is impossible (one command per cycle).
- Response pipeline: LATENCY-stage shift register of {valid, tag, data}.
  - A load accepted at edge t appears on data_tag/data after edge t+LATENCY, held for exactly one cycle.
  - At most one accept per cycle and a fixed latency, so responses never collide; order equals accept order.
- Idle response: data_tag=0 and data=0 when no response is presented (data is not held stale).
- outstanding counter:
  - +1 on load accept, −1 on response emit.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Out-of-range block index (≥ DEPTH_BLOCKS):
  - Load is accepted and returns data=0 with its tag.
  - Store is accepted and its tag issued, but the store is discarded.
- Reserved command 3: behaves as NONE, tag 0, no state change.
- Reset mid-operation: all in-flight responses are dropped, no response is emitted after reset release, and tags restart at 1.

Test Plan:
- Store then load:
  - STORE addr 0x40 data 0xDEADBEEF_CAFEF00D → tag 1.
  - Next cycle LOAD 0x40 → tag 2.
  - 12 cycles later: data_tag=2, data=0xDEADBEEF_CAFEF00D for one cycle, then 0/0.
- Back-to-back loads:
  - 9 consecutive LOADs with LATENCY=12 → tags 1..8 issued, 9th refused (tag 0).
  - 9th is accepted the cycle after the first response retires.
  - Responses return in order with tags 1..8.
- Tag wrap: 16 consecutive STOREs → tags 1..15, then 1; never 0.
- Snapshot ordering:
  - LOAD 0x80 (old value 0x11) accepted, next cycle STORE 0x80 value 0x22.
  - Load response returns 0x11; a subsequent load returns 0x22.
- Stall and reserved command:
  - stall=1 with LOAD → tag 0, next_tag unchanged.
  - cmd=3 → tag 0.
  - Out-of-range LOAD addr 0x0000_2000 (DEPTH=1024) → accepted, data 0.
- Reset mid-flight:
  - Assert reset with 3 loads in flight → data_tag=0 immediately.
  - No responses after release; the first new request gets tag 1.
